// File: rtl/mcdt_pkg.sv
// Shared constants for the mcdt demultiplexer: word width, channel count, id encoding.
// No logic here; the id decode helper maps a legal source id to a one-hot channel select.
package mcdt_pkg;

  localparam int MCDT_DW = 32;
  localparam int NUM_CH  = 3;
  localparam int ID_W    = 2;

  localparam logic [ID_W-1:0] ID_ILLEGAL = 2'd3;

  // Illegal ids decode to no channel at all, so the word can never land in a buffer.
  function automatic logic [NUM_CH-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [NUM_CH-1:0] sel;
    sel = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (id == ID_W'(n)) sel[n] = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mcdt_demux_fifo.sv
// Single-clock show-ahead FIFO: head word registered, visible one cycle after push into empty.
// A push while full is accepted only with a pop on the same edge; the caller flags the drop.
module mcdt_demux_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_vld,
  input  logic [DW-1:0]            push_dat,
  input  logic                     pop_rdy,
  output logic [DW-1:0]            head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] remain;
  logic [DW-1:0] head_q;
  logic [DW-1:0] head_d;
  logic          push;
  logic          pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign pop      = !empty && pop_rdy;
  assign push     = push_vld && (!full || pop);
  assign count    = cnt_q;
  assign head_dat = head_q;

  // The head register is the oldest word after this edge's push/pop settle. When the
  // buffer becomes just the incoming word, take it straight from the input since the
  // memory write lands on the same edge.
  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr + PW'(pop);
    remain   = cnt_q - CW'(pop);
    head_d   = head_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (push && remain == '0) begin
      head_d = push_dat;
    end else if (remain != '0) begin
      head_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/mcdt_demux.sv
// Routes mcdt words to three per-channel show-ahead buffers; one cycle push-to-head latency.
// No input back-pressure: words for a full buffer or an illegal id are dropped and flagged sticky.
module mcdt_demux
  import mcdt_pkg::*;
#(
  parameter int DW    = MCDT_DW,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DW-1:0]            mcdt_data_i,
  input  logic                     mcdt_val_i,
  input  logic [ID_W-1:0]          mcdt_id_i,
  output logic [DW-1:0]            ch0_data_o,
  output logic                     ch0_valid_o,
  input  logic                     ch0_ready_i,
  output logic [$clog2(DEPTH):0]   ch0_count_o,
  output logic [DW-1:0]            ch1_data_o,
  output logic                     ch1_valid_o,
  input  logic                     ch1_ready_i,
  output logic [$clog2(DEPTH):0]   ch1_count_o,
  output logic [DW-1:0]            ch2_data_o,
  output logic                     ch2_valid_o,
  input  logic                     ch2_ready_i,
  output logic [$clog2(DEPTH):0]   ch2_count_o,
  output logic [NUM_CH-1:0]        ovf_o,
  output logic                     id_err_o,
  input  logic                     err_clr_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] ch_push;
  logic [NUM_CH-1:0] ch_rdy;
  logic [NUM_CH-1:0] ch_full;
  logic [NUM_CH-1:0] ch_empty;
  logic [NUM_CH-1:0] ovf_set;
  logic [DW-1:0]     ch_dat [NUM_CH];
  logic [CW-1:0]     ch_cnt [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;
  logic              id_err_q;
  logic              id_err_set;

  assign ch_sel     = id_onehot(mcdt_id_i);
  assign ch_push    = ch_sel & {NUM_CH{mcdt_val_i}};
  assign ch_rdy     = {ch2_ready_i, ch1_ready_i, ch0_ready_i};
  assign id_err_set = mcdt_val_i && (mcdt_id_i == ID_ILLEGAL);

  // A pop on the same edge frees the slot, so only a full buffer with no pop overflows.
  assign ovf_set = ch_push & ch_full & ~(ch_rdy & ~ch_empty);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    mcdt_demux_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_vld (ch_push[n]),
      .push_dat (mcdt_data_i),
      .pop_rdy  (ch_rdy[n]),
      .head_dat (ch_dat[n]),
      .count    (ch_cnt[n]),
      .full     (ch_full[n]),
      .empty    (ch_empty[n])
    );
  end

  // Set beats clear when both happen on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q    <= '0;
      id_err_q <= 1'b0;
    end else begin
      ovf_q    <= ovf_set | (ovf_q & {NUM_CH{~err_clr_i}});
      id_err_q <= id_err_set | (id_err_q & ~err_clr_i);
    end
  end

  assign ovf_o    = ovf_q;
  assign id_err_o = id_err_q;

  assign ch0_data_o  = ch_dat[0];
  assign ch1_data_o  = ch_dat[1];
  assign ch2_data_o  = ch_dat[2];
  assign ch0_count_o = ch_cnt[0];
  assign ch1_count_o = ch_cnt[1];
  assign ch2_count_o = ch_cnt[2];
  assign ch0_valid_o = ~ch_empty[0];
  assign ch1_valid_o = ~ch_empty[1];
  assign ch2_valid_o = ~ch_empty[2];

endmodule

// File: tb/tb_mcdt_demux.sv
// Directed bench for mcdt_demux: fill/overflow, interleave, push+pop at full, id errors, async reset.
module tb_mcdt_demux;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] mcdt_data_i;
  logic        mcdt_val_i;
  logic [1:0]  mcdt_id_i;
  logic [31:0] ch0_data_o, ch1_data_o, ch2_data_o;
  logic        ch0_valid_o, ch1_valid_o, ch2_valid_o;
  logic        ch0_ready_i, ch1_ready_i, ch2_ready_i;
  logic [2:0]  ch0_count_o, ch1_count_o, ch2_count_o;
  logic [2:0]  ovf_o;
  logic        id_err_o;
  logic        err_clr_i;

  logic [31:0] t_dat [3];
  logic        t_vld [3];
  logic [2:0]  t_cnt [3];

  int n_checks = 0;
  int n_fail   = 0;

  assign t_dat[0] = ch0_data_o;
  assign t_dat[1] = ch1_data_o;
  assign t_dat[2] = ch2_data_o;
  assign t_vld[0] = ch0_valid_o;
  assign t_vld[1] = ch1_valid_o;
  assign t_vld[2] = ch2_valid_o;
  assign t_cnt[0] = ch0_count_o;
  assign t_cnt[1] = ch1_count_o;
  assign t_cnt[2] = ch2_count_o;

  mcdt_demux #(.DW(32), .DEPTH(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mcdt_data_i (mcdt_data_i),
    .mcdt_val_i  (mcdt_val_i),
    .mcdt_id_i   (mcdt_id_i),
    .ch0_data_o  (ch0_data_o),
    .ch0_valid_o (ch0_valid_o),
    .ch0_ready_i (ch0_ready_i),
    .ch0_count_o (ch0_count_o),
    .ch1_data_o  (ch1_data_o),
    .ch1_valid_o (ch1_valid_o),
    .ch1_ready_i (ch1_ready_i),
    .ch1_count_o (ch1_count_o),
    .ch2_data_o  (ch2_data_o),
    .ch2_valid_o (ch2_valid_o),
    .ch2_ready_i (ch2_ready_i),
    .ch2_count_o (ch2_count_o),
    .ovf_o       (ovf_o),
    .id_err_o    (id_err_o),
    .err_clr_i   (err_clr_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; mcdt_val_i = 1'b0; mcdt_id_i = 2'd0; mcdt_data_i = '0; err_clr_i = 1'b0;
    ch0_ready_i = 1'b0; ch1_ready_i = 1'b0; ch2_ready_i = 1'b0;
    step(); step();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (t_cnt[c] !== 3'd0) begin n_fail++; $display("FAIL reset_count ch%0d: got %0d expected 0", c, t_cnt[c]); end
      n_checks++;
      if (t_vld[c] !== 1'b0) begin n_fail++; $display("FAIL reset_valid ch%0d: got %b expected 0", c, t_vld[c]); end
      n_checks++;
      if (t_dat[c] !== 32'h0) begin n_fail++; $display("FAIL reset_data ch%0d: got %h expected 0", c, t_dat[c]); end
    end
    n_checks++;
    if (ovf_o !== 3'b000) begin n_fail++; $display("FAIL reset_ovf: got %b expected 000", ovf_o); end
    n_checks++;
    if (id_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_id_err: got %b expected 0", id_err_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_fill();
    mcdt_val_i = 1'b1; mcdt_id_i = 2'd0; mcdt_data_i = 32'h00C0_0000;
    #1;
    n_checks++;
    if (ch0_valid_o !== 1'b0) begin n_fail++; $display("FAIL fill_no_bypass: got %b expected 0", ch0_valid_o); end
    for (int k = 0; k < 4; k++) begin
      mcdt_data_i = 32'h00C0_0000 + 32'(k);
      step();
      n_checks++;
      if (ch0_count_o !== 3'(k + 1)) begin n_fail++; $display("FAIL fill_count k=%0d: got %0d expected %0d", k, ch0_count_o, k + 1); end
      n_checks++;
      if (ch0_valid_o !== 1'b1 || ch0_data_o !== 32'h00C0_0000) begin
        n_fail++; $display("FAIL fill_head k=%0d: got %b/%h expected 1/00c00000", k, ch0_valid_o, ch0_data_o);
      end
    end
    mcdt_val_i = 1'b0;
    n_checks++;
    if (ch1_valid_o !== 1'b0 || ch2_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL fill_other_valid: got %b%b expected 00", ch1_valid_o, ch2_valid_o);
    end
  endtask

  task automatic test_overflow();
    mcdt_val_i = 1'b1; mcdt_id_i = 2'd0; mcdt_data_i = 32'h00C0_0004;
    step();
    mcdt_val_i = 1'b0;
    n_checks++;
    if (ovf_o !== 3'b001) begin n_fail++; $display("FAIL ovf_set: got %b expected 001", ovf_o); end
    n_checks++;
    if (ch0_count_o !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", ch0_count_o); end
    ch0_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ch0_data_o !== 32'h00C0_0000 + 32'(k)) begin
        n_fail++; $display("FAIL ovf_drain k=%0d: got %h expected %h", k, ch0_data_o, 32'h00C0_0000 + 32'(k));
      end
      step();
    end
    n_checks++;
    if (ch0_count_o !== 3'd0 || ch0_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_empty: got %0d/%b expected 0/0", ch0_count_o, ch0_valid_o);
    end
    n_checks++;
    if (ovf_o !== 3'b001) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 001", ovf_o); end
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    n_checks++;
    if (ovf_o !== 3'b000) begin n_fail++; $display("FAIL ovf_clear: got %b expected 000", ovf_o); end
  endtask

  task automatic test_interleave();
    logic [31:0] exp_dat;
    int          id;
    ch0_ready_i = 1'b1; ch1_ready_i = 1'b1; ch2_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      id = i % 3;
      exp_dat = 32'h00C0_0000 | (32'(id) << 16) | 32'(i / 3);
      mcdt_val_i = 1'b1; mcdt_id_i = 2'(id); mcdt_data_i = exp_dat;
      step();
      n_checks++;
      if (t_vld[id] !== 1'b1 || t_dat[id] !== exp_dat || t_cnt[id] !== 3'd1) begin
        n_fail++; $display("FAIL interleave i=%0d: got %b/%h/%0d expected 1/%h/1", i, t_vld[id], t_dat[id], t_cnt[id], exp_dat);
      end
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (t_cnt[c] > 3'd1) begin n_fail++; $display("FAIL interleave_cnt i=%0d ch%0d: got %0d expected <=1", i, c, t_cnt[c]); end
      end
    end
    mcdt_val_i = 1'b0;
    step();
    n_checks++;
    if (ch0_count_o !== 3'd0 || ch1_count_o !== 3'd0 || ch2_count_o !== 3'd0) begin
      n_fail++; $display("FAIL interleave_drain: got %0d %0d %0d expected 0 0 0", ch0_count_o, ch1_count_o, ch2_count_o);
    end
  endtask

  task automatic test_full_push_pop();
    ch1_ready_i = 1'b0;
    mcdt_val_i = 1'b1; mcdt_id_i = 2'd1;
    for (int k = 5; k < 9; k++) begin
      mcdt_data_i = 32'h00C1_0000 + 32'(k);
      step();
    end
    mcdt_val_i = 1'b0;
    n_checks++;
    if (ch1_count_o !== 3'd4) begin n_fail++; $display("FAIL fpp_fill: got %0d expected 4", ch1_count_o); end
    ch1_ready_i = 1'b1; mcdt_val_i = 1'b1; mcdt_data_i = 32'h00C1_0009;
    step();
    mcdt_val_i = 1'b0;
    n_checks++;
    if (ch1_count_o !== 3'd4) begin n_fail++; $display("FAIL fpp_count: got %0d expected 4", ch1_count_o); end
    n_checks++;
    if (ovf_o !== 3'b000) begin n_fail++; $display("FAIL fpp_ovf: got %b expected 000", ovf_o); end
    for (int k = 6; k < 10; k++) begin
      n_checks++;
      if (ch1_data_o !== 32'h00C1_0000 + 32'(k)) begin
        n_fail++; $display("FAIL fpp_order k=%0d: got %h expected %h", k, ch1_data_o, 32'h00C1_0000 + 32'(k));
      end
      step();
    end
    n_checks++;
    if (ch1_count_o !== 3'd0) begin n_fail++; $display("FAIL fpp_empty: got %0d expected 0", ch1_count_o); end
    mcdt_val_i = 1'b1; mcdt_data_i = 32'h00C1_000A;
    step();
    n_checks++;
    if (ch1_count_o !== 3'd1 || ch1_data_o !== 32'h00C1_000A) begin
      n_fail++; $display("FAIL fpp_one_a: got %0d/%h expected 1/00c1000a", ch1_count_o, ch1_data_o);
    end
    mcdt_data_i = 32'h00C1_000B;
    step();
    mcdt_val_i = 1'b0;
    n_checks++;
    if (ch1_count_o !== 3'd1 || ch1_data_o !== 32'h00C1_000B) begin
      n_fail++; $display("FAIL fpp_one_b: got %0d/%h expected 1/00c1000b", ch1_count_o, ch1_data_o);
    end
    step();
    n_checks++;
    if (ch1_count_o !== 3'd0) begin n_fail++; $display("FAIL fpp_one_drain: got %0d expected 0", ch1_count_o); end
  endtask

  task automatic test_id_err();
    ch2_ready_i = 1'b0;
    mcdt_val_i = 1'b1; mcdt_id_i = 2'd2; mcdt_data_i = 32'h00C2_0000;
    step();
    mcdt_id_i = 2'd3; mcdt_data_i = 32'hDEAD_BEEF;
    step();
    mcdt_val_i = 1'b0;
    n_checks++;
    if (id_err_o !== 1'b1) begin n_fail++; $display("FAIL id_err_set: got %b expected 1", id_err_o); end
    n_checks++;
    if (ch0_count_o !== 3'd0 || ch1_count_o !== 3'd0 || ch2_count_o !== 3'd1) begin
      n_fail++; $display("FAIL id_err_counts: got %0d %0d %0d expected 0 0 1", ch0_count_o, ch1_count_o, ch2_count_o);
    end
    n_checks++;
    if (ch2_data_o !== 32'h00C2_0000 || ovf_o !== 3'b000) begin
      n_fail++; $display("FAIL id_err_nochange: got %h/%b expected 00c20000/000", ch2_data_o, ovf_o);
    end
    mcdt_val_i = 1'b1; err_clr_i = 1'b1;
    step();
    mcdt_val_i = 1'b0;
    n_checks++;
    if (id_err_o !== 1'b1) begin n_fail++; $display("FAIL id_err_set_wins: got %b expected 1", id_err_o); end
    step();
    err_clr_i = 1'b0;
    n_checks++;
    if (id_err_o !== 1'b0) begin n_fail++; $display("FAIL id_err_clear: got %b expected 0", id_err_o); end
    ch2_ready_i = 1'b1;
    step();
    ch2_ready_i = 1'b0;
    n_checks++;
    if (ch2_count_o !== 3'd0) begin n_fail++; $display("FAIL id_err_drain: got %0d expected 0", ch2_count_o); end
  endtask

  task automatic test_async_reset();
    ch2_ready_i = 1'b0;
    mcdt_val_i = 1'b1; mcdt_id_i = 2'd2;
    mcdt_data_i = 32'h00C2_0001;
    step();
    mcdt_data_i = 32'h00C2_0002;
    step();
    mcdt_val_i = 1'b0;
    n_checks++;
    if (ch2_count_o !== 3'd2 || ch2_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre: got %0d/%b expected 2/1", ch2_count_o, ch2_valid_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (ch2_valid_o !== 1'b0 || ch2_count_o !== 3'd0 || ch2_data_o !== 32'h0) begin
      n_fail++; $display("FAIL arst_immediate: got %b/%0d/%h expected 0/0/0", ch2_valid_o, ch2_count_o, ch2_data_o);
    end
    step();
    rst_i = 1'b0;
    ch2_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (ch2_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_after k=%0d: got valid %b expected 0", k, ch2_valid_o); end
    end
    mcdt_val_i = 1'b1; mcdt_data_i = 32'h00C2_0003;
    step();
    mcdt_val_i = 1'b0;
    n_checks++;
    if (ch2_valid_o !== 1'b1 || ch2_data_o !== 32'h00C2_0003) begin
      n_fail++; $display("FAIL arst_resume: got %b/%h expected 1/00c20003", ch2_valid_o, ch2_data_o);
    end
    step();
    n_checks++;
    if (ch2_count_o !== 3'd0) begin n_fail++; $display("FAIL arst_resume_drain: got %0d expected 0", ch2_count_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_interleave();
    test_full_push_pop();
    test_id_err();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
